// File: rtl/wb_spi_slave.sv
// SPI mode-0 responder (MSB first, 8-bit frames) with a Wishbone classic register port.
// External sclk/cs/mosi are oversampled in the clk domain; all outputs are registered.
module wb_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DUMMY       = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        irq
);

    localparam int unsigned S = SYNC_STAGES;

    // One extra flop beyond the synchronizer gives the previous value for edge detection.
    logic [S:0]   sclk_s_q, cs_s_q;
    logic [S-1:0] mosi_s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s_q <= '0;
            cs_s_q   <= '1;
            mosi_s_q <= '0;
        end else begin
            sclk_s_q <= {sclk_s_q[S-1:0], sclk};
            cs_s_q   <= {cs_s_q[S-1:0], cs};
            mosi_s_q <= {mosi_s_q[S-1:0], mosi};
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_active, mosi_sync;
    assign sclk_rise = sclk_s_q[S-1] & ~sclk_s_q[S];
    assign sclk_fall = ~sclk_s_q[S-1] & sclk_s_q[S];
    assign cs_rise   = cs_s_q[S-1] & ~cs_s_q[S];
    assign cs_fall   = ~cs_s_q[S-1] & cs_s_q[S];
    assign cs_active = ~cs_s_q[S-1];
    assign mosi_sync = mosi_s_q[S-1];

    logic       wb_req, wb_wr, wb_rd;
    logic [1:0] adr;
    logic       unused_ok;
    assign wb_req    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wb_wr     = wb_req & wb_we_i;
    assign wb_rd     = wb_req & ~wb_we_i;
    assign adr       = wb_adr_i[3:2];
    assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  tx_buf_q, tx_buf_d;
    logic        tx_empty_q, tx_empty_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        miso_q, miso_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  tx_load;

    assign tx_load = tx_empty_q ? DUMMY : tx_buf_q;

    always_comb begin
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        tx_shift_d = tx_shift_q;
        miso_d     = miso_q;
        ack_d      = wb_req;
        dat_d      = '0;

        // Bus side effects first so SPI events below take priority over them.
        if (wb_rd) begin
            case (adr)
                2'd1:    begin
                    dat_d      = {24'h0, rx_data_q};
                    rx_valid_d = 1'b0;
                end
                2'd2:    dat_d = {28'h0, cs_active, overrun_q, tx_empty_q, rx_valid_q};
                default: dat_d = '0;
            endcase
        end
        if (wb_wr && adr == 2'd2 && wb_dat_i[2]) begin
            overrun_d = 1'b0;
        end

        if (cs_fall) begin
            cnt_d      = '0;
            rx_shift_d = '0;
            tx_shift_d = tx_load;
            miso_d     = tx_load[7];
            tx_empty_d = 1'b1;
        end else if (cs_rise) begin
            cnt_d      = '0;
            rx_shift_d = '0;
            miso_d     = 1'b0;
        end else if (cs_active && sclk_rise) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_sync};
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                rx_data_d  = {rx_shift_q, mosi_sync};
                rx_valid_d = 1'b1;
                if (rx_valid_q) begin
                    overrun_d = 1'b1;
                end
            end
        end else if (cs_active && sclk_fall) begin
            if (cnt_q != 3'd0) begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
                miso_d     = tx_shift_q[6];
            end else begin
                tx_shift_d = tx_load;
                miso_d     = tx_load[7];
                tx_empty_d = 1'b1;
            end
        end

        // A write in the same cycle as a consume refills the buffer after the old value is taken.
        if (wb_wr && adr == 2'd0) begin
            tx_buf_d   = wb_dat_i[7:0];
            tx_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            tx_buf_q   <= '0;
            tx_empty_q <= 1'b1;
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            tx_buf_q   <= tx_buf_d;
            tx_empty_q <= tx_empty_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign miso     = miso_q;
    assign irq      = rx_valid_q | overrun_q;

endmodule

// File: doc/wb_spi_slave.md
# wb_spi_slave

SPI responder (mode 0, MSB first, 8-bit frames) with a Wishbone slave register port; the device-side counterpart of the `wb_spi` master. It oversamples the external `sclk`/`cs`/`mosi` in the system `clk` domain, shifts received bytes into a holding register, and shifts a CPU-loaded byte out on `miso`. It sits on the peripheral Wishbone bus behind the interconnect's base-address decode.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sclk`, `cs`, `mosi` (≥2).
- `DUMMY`, 8'h00: byte shifted out when no TX byte is loaded.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wb_adr_i` in 32: only bits [3:2] decoded.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data; unused bits 0.
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i` in 1 each: Wishbone classic controls.
- `wb_ack_o` out 1: registered single-cycle acknowledge.
- `sclk` in 1: SPI clock from master, idle low.
- `cs` in 1: active-low chip select.
- `mosi` in 1: master-to-slave data.
- `miso` out 1: slave-to-master data; driven 0 while `cs` high (no tristate).
- `irq` out 1: `rx_valid | overrun`.

## Operation
- Registers, by `wb_adr_i[3:2]`:
  - 0 TXDATA, W: `[7:0]` loads the TX buffer and clears `tx_empty`.
  - 1 RXDATA, R: last received byte; a read clears `rx_valid`.
  - 2 STATUS, R: bit0 `rx_valid`, bit1 `tx_empty`, bit2 `overrun`, bit3 `busy` (synced cs low). Writing 1 to bit2 clears `overrun`.
  - 3: reads 0; writes ignored.
- Synchronized `sclk`/`cs` are edge-detected in `clk`. Rise and fall are one-cycle strobes taken from the last two sync stages.
- `cs` fall: bit counter = 0. Shift-out register loads the TX buffer if `!tx_empty`, else `DUMMY`. The TX buffer is consumed (`tx_empty` = 1). `miso` = bit 7.
- `sclk` rise while `cs` low: shift synced `mosi` into the RX shift register LSB, then increment the 3-bit bit counter (wraps 7→0).
  - On the 8th rise (counter 7→0): RXDATA = completed byte, `rx_valid` = 1. If `rx_valid` was already 1, `overrun` = 1 and RXDATA is overwritten with the new byte.
- `sclk` fall while `cs` low:
  - Counter ≠ 0: shift-out register shifts left and `miso` presents the next bit.
  - Counter = 0 (byte boundary): reload from the TX buffer or `DUMMY` as on `cs` fall, consuming the buffer.
- `cs` rise mid-byte: partial RX bits are discarded and the counter is reset. RXDATA and `rx_valid` are unchanged; `miso` → 0.
- Simultaneous events:
  - RX completion and a RXDATA read in the same cycle: completion wins (`rx_valid` stays 1; the read returns the old byte).
  - TX consume and a TXDATA write in the same cycle: the shift register takes the old buffer value, then the buffer holds the new write with `tx_empty` = 0.
  - TXDATA write while the buffer is full: overwrites it.
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `miso`=0, `irq`=0, `rx_valid`=0, `tx_empty`=1, `overrun`=0, RXDATA=0, counter=0. All sync flops reset to idle (`sclk`=0, `cs`=1).

## Timing
- Wishbone transfer:
  - A transfer is accepted when `stb & cyc & !ack` is sampled. The write takes effect at that edge.
  - `wb_ack_o` and `wb_dat_o` are valid the following cycle, for exactly one cycle.
  - A one-cycle `stb` pulse is sufficient. Back-to-back accesses take 2 cycles each.
- External edge latency: an edge on `sclk`/`cs` is acted on `SYNC_STAGES+1` clk cycles later.
- `miso` timing:
  - `miso` updates 1 cycle after the internal `cs`-fall or `sclk`-fall strobe.
  - The first bit is valid ≤ `SYNC_STAGES+2` cycles after `cs` falls.
- Requirements on the master:
  - `sclk` high and low phases each ≥ `SYNC_STAGES+3` clk cycles (sclk ≤ clk/10 at defaults).
  - `cs` fall to first `sclk` rise ≥ the same.
- `rx_valid` sets 1 cycle after the 8th rise strobe.

## Test plan
- Reset → STATUS read returns 0x2. `miso`=0, `irq`=0, all Wishbone reads are 0 except STATUS.
- Write TXDATA=0xA5. Master sends 0x3C in one `cs` frame → master receives 0xA5. RXDATA=0x3C, STATUS=0x3, `irq`=1. Reading RXDATA clears bit0.
- Two bytes 0x11, 0x22 in one frame, no RXDATA read, TX not reloaded → master gets 0xA5 then `DUMMY` 0x00. RXDATA=0x22, `overrun`=1. Writing STATUS=0x4 clears it.
- `cs` deasserted after 5 bits, then a full frame 0x81 → RXDATA=0x81, no spurious `rx_valid` from the partial byte.
- RXDATA read issued on the same cycle `rx_valid` sets → the read returns the old byte and `rx_valid` stays 1. Assert `rst` low mid-frame → all outputs return to reset values immediately.
